// File: rtl/c7bifu_pkg.sv
// -----------------------------------------------------------------------------
// c7bifu_pkg -- shared types and constants for the instruction fetch control
// unit (c7bifu_fcu) and its helpers.
//
// Contents:
//   fcu_state_e  : fetch FSM state encoding (IDLE, REQ, WAIT, HOLD, DROP)
//   NOP_INST     : instruction substituted into the low word of a beat whose
//                  redirect target pointed at the upper word
//   FETCH_BYTES  : bytes per fetch beat (one 64-bit memory read)
//   align8()     : clears the low three address bits (beat alignment)
// -----------------------------------------------------------------------------
package c7bifu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fcu_state_e;

    localparam logic [31:0] NOP_INST    = 32'h0340_0000;
    localparam logic [31:0] FETCH_BYTES = 32'd8;

    // Beat-aligned form of a byte address.
    function automatic logic [31:0] align8(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/c7bifu_fcu_if.sv
// -----------------------------------------------------------------------------
// c7bifu_fcu_if -- bus bundle between the fetch control unit, the memory read
// port and the downstream instruction queue.
//
// Signals:
//   ifu_req / ifu_req_addr / ifu_req_ack : read request handshake (aligned addr)
//   mem_rvld / mem_rdata                 : 64-bit in-order read response
//   data / data_addr / data_vld          : delivered beat towards the queue
//   iq_full                              : queue back-pressure
//
// Modports:
//   master : the fetch control unit side (drives requests and beats)
//   slave  : the memory + instruction queue side
// -----------------------------------------------------------------------------
interface c7bifu_fcu_if;

    logic        ifu_req;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ack;
    logic        mem_rvld;
    logic [63:0] mem_rdata;
    logic [31:0] data_addr;
    logic [63:0] data;
    logic        data_vld;
    logic        iq_full;

    modport master (
        output ifu_req,
        output ifu_req_addr,
        input  ifu_req_ack,
        input  mem_rvld,
        input  mem_rdata,
        output data_addr,
        output data,
        output data_vld,
        input  iq_full
    );

    modport slave (
        input  ifu_req,
        input  ifu_req_addr,
        output ifu_req_ack,
        output mem_rvld,
        output mem_rdata,
        input  data_addr,
        input  data,
        input  data_vld,
        output iq_full
    );

endinterface

// File: rtl/c7bifu_fcu_perf.sv
// -----------------------------------------------------------------------------
// c7bifu_fcu_perf -- free-running performance counters for the fetch unit.
//
// Ports:
//   clk, resetn     : clock, asynchronous active-low reset (only clear source)
//   beat_inc        : one beat transferred to the instruction queue this cycle
//   stall_inc       : beat held in HOLD because the queue is full this cycle
//   fcu_beat_cnt    : transferred-beat count, wraps at 2^32
//   fcu_stall_cnt   : back-pressure cycle count, wraps at 2^32
//
// Instantiated by c7bifu_fcu only when C7BIFU_FCU_PERF_EN is defined.
// -----------------------------------------------------------------------------
module c7bifu_fcu_perf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        beat_inc,
    input  logic        stall_inc,
    output logic [31:0] fcu_beat_cnt,
    output logic [31:0] fcu_stall_cnt
);

    logic [31:0] beat_cnt_r;
    logic [31:0] stall_cnt_r;

    // Beat counter: counts every accepted beat, wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt_r <= 32'd0;
        end else if (beat_inc) begin
            beat_cnt_r <= beat_cnt_r + 32'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Stall counter: counts HOLD cycles spent waiting on a full queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_inc) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign fcu_beat_cnt  = beat_cnt_r;
    assign fcu_stall_cnt = stall_cnt_r;

endmodule

// File: rtl/c7bifu_fcu.sv
// -----------------------------------------------------------------------------
// c7bifu_fcu -- instruction fetch control unit.
//
// Issues one 8-byte aligned memory read at a time, captures the 64-bit
// response and presents it to the instruction queue, then advances to the
// next beat. A flush redirects fetch to a new PC and discards any response
// still in flight. When the redirect target is the upper word of a beat the
// lower word of that beat is replaced by NOP_INST so the queue never sees the
// instruction preceding the target.
//
// Parameters:
//   RESET_PC : first fetch address after reset
//
// Ports:
//   clk, resetn     : clock, asynchronous active-low reset
//   flush, flush_pc : single-cycle redirect strobe and target (bits [1:0] ignored)
//   bus             : c7bifu_fcu_if.master (request, response, beat, back-pressure)
//   fcu_beat_cnt    : transferred beats   (only with C7BIFU_FCU_PERF_EN)
//   fcu_stall_cnt   : full-queue HOLD cycles (only with C7BIFU_FCU_PERF_EN)
//
// Configuration macro: C7BIFU_FCU_PERF_EN enables the performance counters.
// -----------------------------------------------------------------------------
module c7bifu_fcu
    import c7bifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
`ifdef C7BIFU_FCU_PERF_EN
    output logic [31:0] fcu_beat_cnt,
    output logic [31:0] fcu_stall_cnt,
`endif
    c7bifu_fcu_if.master bus
);

    fcu_state_e  state_r;
    fcu_state_e  state_nxt_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] fetch_pc_nxt_s;
    logic        nop_r;
    logic        nop_nxt_s;
    logic        ifu_req_r;
    logic [31:0] ifu_req_addr_r;
    logic        data_vld_r;
    logic [63:0] data_r;
    logic [31:0] data_addr_r;

    logic        ack_s;
    logic        transfer_s;
    logic        load_s;
    logic        stall_s;

    assign ack_s      = ifu_req_r && bus.ifu_req_ack;
    assign transfer_s = data_vld_r && !bus.iq_full;
    assign stall_s    = (state_r == HOLD) && bus.iq_full;

    // Next-state, next fetch PC, NOP flag and response-capture decision.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        nop_nxt_s      = nop_r;
        load_s         = 1'b0;
        if (flush) begin
            // Redirect wins over everything; a response already owed by the
            // memory must be swallowed in DROP before a new request issues.
            fetch_pc_nxt_s = {flush_pc[31:2], 2'b00};
            nop_nxt_s      = flush_pc[2];
            case (state_r)
                IDLE:    state_nxt_s = REQ;
                REQ:     state_nxt_s = ack_s ? DROP : REQ;
                WAIT:    state_nxt_s = bus.mem_rvld ? REQ : DROP;
                HOLD:    state_nxt_s = REQ;
                DROP:    state_nxt_s = bus.mem_rvld ? REQ : DROP;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = REQ;
                end
                REQ: begin
                    if (ack_s) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvld) begin
                        load_s      = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                HOLD: begin
                    if (transfer_s) begin
                        fetch_pc_nxt_s = align8(fetch_pc_r) + FETCH_BYTES;
                        nop_nxt_s      = 1'b0;
                        state_nxt_s    = REQ;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                DROP: begin
                    if (bus.mem_rvld) begin
                        state_nxt_s = REQ;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // FSM state, fetch PC and NOP-substitution flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            nop_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            nop_r      <= nop_nxt_s;
        end
    end

    // Request outputs, registered from the next state so they line up with REQ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ifu_req_r      <= 1'b0;
            ifu_req_addr_r <= 32'd0;
        end else if (state_nxt_s == REQ) begin
            ifu_req_r      <= 1'b1;
            ifu_req_addr_r <= align8(fetch_pc_nxt_s);
        end else begin
            ifu_req_r      <= 1'b0;
            ifu_req_addr_r <= ifu_req_addr_r;
        end
    end

    // Beat valid: high exactly while the FSM sits in HOLD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_vld_r <= 1'b0;
        end else begin
            data_vld_r <= (state_nxt_s == HOLD);
        end
    end

    // Beat capture; the low word is swapped for a NOP when fetch was
    // redirected into the upper word of this beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_r      <= 64'd0;
            data_addr_r <= 32'd0;
        end else if (load_s) begin
            data_r      <= {bus.mem_rdata[63:32], (nop_r ? NOP_INST : bus.mem_rdata[31:0])};
            data_addr_r <= align8(fetch_pc_r);
        end else begin
            data_r      <= data_r;
            data_addr_r <= data_addr_r;
        end
    end

    assign bus.ifu_req      = ifu_req_r;
    assign bus.ifu_req_addr = ifu_req_addr_r;
    assign bus.data_vld     = data_vld_r;
    assign bus.data         = data_r;
    assign bus.data_addr    = data_addr_r;

`ifdef C7BIFU_FCU_PERF_EN
    c7bifu_fcu_perf u_perf (
        .clk           (clk),
        .resetn        (resetn),
        .beat_inc      (transfer_s),
        .stall_inc     (stall_s),
        .fcu_beat_cnt  (fcu_beat_cnt),
        .fcu_stall_cnt (fcu_stall_cnt)
    );
`else
    logic unused_perf_s;
    assign unused_perf_s = stall_s;
`endif

endmodule

// File: tb/tb_c7bifu_fcu.sv
// -----------------------------------------------------------------------------
// tb_c7bifu_fcu -- directed self-checking bench for c7bifu_fcu.
// Inputs are driven 1 ns after the rising edge and outputs are sampled at the
// same point, so every value seen reflects the state after that edge.
// -----------------------------------------------------------------------------
module tb_c7bifu_fcu;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [31:0] flush_pc;
`ifdef C7BIFU_FCU_PERF_EN
    logic [31:0] fcu_beat_cnt;
    logic [31:0] fcu_stall_cnt;
`endif

    int n_checks;
    int n_fail;

    c7bifu_fcu_if bus ();

    c7bifu_fcu #(.RESET_PC(32'h1c00_0000)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .flush_pc      (flush_pc),
`ifdef C7BIFU_FCU_PERF_EN
        .fcu_beat_cnt  (fcu_beat_cnt),
        .fcu_stall_cnt (fcu_stall_cnt),
`endif
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From REQ: accept the request, return rd next cycle; leaves FSM in HOLD.
    task automatic drive_to_hold(input logic [63:0] rd);
        bus.ifu_req_ack = 1'b1;
        step();
        bus.ifu_req_ack = 1'b0;
        bus.mem_rvld    = 1'b1;
        bus.mem_rdata   = rd;
        step();
        bus.mem_rvld    = 1'b0;
        bus.mem_rdata   = 64'd0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; flush_pc = 32'd0;
        bus.ifu_req_ack = 1'b0; bus.mem_rvld = 1'b0;
        bus.mem_rdata = 64'd0; bus.iq_full = 1'b0;
        step(); step();
        n_checks++;
        if ({bus.ifu_req, bus.ifu_req_addr, bus.data_vld, bus.data, bus.data_addr} !== 130'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%0b addr=%h vld=%0b data=%h daddr=%h, required all zero",
                     bus.ifu_req, bus.ifu_req_addr, bus.data_vld, bus.data, bus.data_addr);
        end
        resetn = 1'b1;
        n_checks++;
        if (bus.ifu_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: ifu_req=%0b required 0", bus.ifu_req);
        end
        step();
        n_checks++;
        if (bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%0b addr=%h required 1/1c000000", bus.ifu_req, bus.ifu_req_addr);
        end
    endtask

    task automatic test_basic();
        drive_to_hold(64'h1111_1111_2222_2222);
        n_checks++;
        if (bus.data_vld !== 1'b1 || bus.data !== 64'h1111_1111_2222_2222 || bus.data_addr !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL basic_beat: vld=%0b data=%h daddr=%h required 1/1111111122222222/1c000000",
                     bus.data_vld, bus.data, bus.data_addr);
        end
        n_checks++;
        if (bus.ifu_req !== 1'b0) begin
            n_fail++; $display("FAIL basic_no_req_in_hold: ifu_req=%0b required 0", bus.ifu_req);
        end
        step();
        n_checks++;
        if (bus.data_vld !== 1'b0 || bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'h1c00_0008) begin
            n_fail++;
            $display("FAIL basic_next_req: vld=%0b req=%0b addr=%h required 0/1/1c000008",
                     bus.data_vld, bus.ifu_req, bus.ifu_req_addr);
        end
    endtask

    task automatic test_hold_stall();
        bus.iq_full = 1'b1;
        drive_to_hold(64'hAAAA_BBBB_CCCC_DDDD);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.data_vld !== 1'b1 || bus.data !== 64'hAAAA_BBBB_CCCC_DDDD || bus.data_addr !== 32'h1c00_0008) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: vld=%0b data=%h daddr=%h required 1/aaaabbbbccccdddd/1c000008",
                         i, bus.data_vld, bus.data, bus.data_addr);
            end
            if (i < 5) step();
        end
`ifdef C7BIFU_FCU_PERF_EN
        n_checks++;
        if (fcu_stall_cnt !== 32'd5) begin
            n_fail++; $display("FAIL perf_stall_cnt: got %0d required 5", fcu_stall_cnt);
        end
`endif
        bus.iq_full = 1'b0;
        step();
        n_checks++;
        if (bus.data_vld !== 1'b0 || bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'h1c00_0010) begin
            n_fail++;
            $display("FAIL hold_release: vld=%0b req=%0b addr=%h required 0/1/1c000010",
                     bus.data_vld, bus.ifu_req, bus.ifu_req_addr);
        end
`ifdef C7BIFU_FCU_PERF_EN
        n_checks++;
        if (fcu_beat_cnt !== 32'd2) begin
            n_fail++; $display("FAIL perf_beat_cnt: got %0d required 2", fcu_beat_cnt);
        end
`endif
    endtask

    task automatic test_flush_wait();
        bus.ifu_req_ack = 1'b1;
        step();
        bus.ifu_req_ack = 1'b0;
        flush = 1'b1; flush_pc = 32'h1c00_0104;
        step();
        flush = 1'b0; flush_pc = 32'd0;
        step();
        n_checks++;
        if (bus.ifu_req !== 1'b0 || bus.data_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_wait: req=%0b vld=%0b required 0/0", bus.ifu_req, bus.data_vld);
        end
        bus.mem_rvld = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_CAFE_BABE;
        step();
        bus.mem_rvld = 1'b0; bus.mem_rdata = 64'd0;
        n_checks++;
        if (bus.data_vld !== 1'b0 || bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'h1c00_0100) begin
            n_fail++;
            $display("FAIL drop_discard: vld=%0b req=%0b addr=%h required 0/1/1c000100",
                     bus.data_vld, bus.ifu_req, bus.ifu_req_addr);
        end
        drive_to_hold(64'h5555_5555_6666_6666);
        n_checks++;
        if (bus.data !== 64'h5555_5555_0340_0000 || bus.data_addr !== 32'h1c00_0100) begin
            n_fail++;
            $display("FAIL nop_insert: data=%h daddr=%h required 5555555503400000/1c000100", bus.data, bus.data_addr);
        end
        step();
        n_checks++;
        if (bus.ifu_req_addr !== 32'h1c00_0108) begin
            n_fail++; $display("FAIL nop_next_req: addr=%h required 1c000108", bus.ifu_req_addr);
        end
        drive_to_hold(64'h7777_7777_8888_8888);
        n_checks++;
        if (bus.data !== 64'h7777_7777_8888_8888) begin
            n_fail++; $display("FAIL nop_cleared: data=%h required 7777777788888888", bus.data);
        end
        step();
    endtask

    task automatic test_flush_rvld();
        bus.ifu_req_ack = 1'b1;
        step();
        bus.ifu_req_ack = 1'b0;
        bus.mem_rvld = 1'b1; bus.mem_rdata = 64'h1234_5678_9ABC_DEF0;
        flush = 1'b1; flush_pc = 32'h2000_0013;
        step();
        bus.mem_rvld = 1'b0; bus.mem_rdata = 64'd0;
        flush = 1'b0; flush_pc = 32'd0;
        n_checks++;
        if (bus.data_vld !== 1'b0 || bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'h2000_0010) begin
            n_fail++;
            $display("FAIL flush_rvld: vld=%0b req=%0b addr=%h required 0/1/20000010",
                     bus.data_vld, bus.ifu_req, bus.ifu_req_addr);
        end
        bus.mem_rvld = 1'b1;
        step();
        bus.mem_rvld = 1'b0;
        n_checks++;
        if (bus.data_vld !== 1'b0 || bus.ifu_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rvld_in_req_ignored: vld=%0b req=%0b required 0/1", bus.data_vld, bus.ifu_req);
        end
    endtask

    task automatic test_wrap();
        flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
        step();
        flush = 1'b0; flush_pc = 32'd0;
        n_checks++;
        if (bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_req: req=%0b addr=%h required 1/fffffff8", bus.ifu_req, bus.ifu_req_addr);
        end
        drive_to_hold(64'h0BAD_F00D_0000_0001);
        n_checks++;
        if (bus.data_addr !== 32'hFFFF_FFF8 || bus.data !== 64'h0BAD_F00D_0000_0001) begin
            n_fail++;
            $display("FAIL wrap_beat: daddr=%h data=%h required fffffff8/0badf00d00000001", bus.data_addr, bus.data);
        end
        step();
        n_checks++;
        if (bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_next: req=%0b addr=%h required 1/00000000", bus.ifu_req, bus.ifu_req_addr);
        end
    endtask

    task automatic test_flush_hold();
        bus.iq_full = 1'b1;
        drive_to_hold(64'h0000_0000_0000_0001);
        flush = 1'b1; flush_pc = 32'h0000_0404;
        step();
        flush = 1'b0;
        n_checks++;
        if (bus.data_vld !== 1'b0 || bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL flush_hold: vld=%0b req=%0b addr=%h required 0/1/00000400",
                     bus.data_vld, bus.ifu_req, bus.ifu_req_addr);
        end
        bus.iq_full = 1'b0;
        flush = 1'b1; flush_pc = 32'h0000_0808;
        step();
        flush = 1'b0; flush_pc = 32'd0;
        n_checks++;
        if (bus.ifu_req_addr !== 32'h0000_0808) begin
            n_fail++; $display("FAIL flush_in_req: addr=%h required 00000808", bus.ifu_req_addr);
        end
        drive_to_hold(64'h9999_9999_AAAA_AAAA);
        n_checks++;
        if (bus.data !== 64'h9999_9999_AAAA_AAAA || bus.data_addr !== 32'h0000_0808) begin
            n_fail++;
            $display("FAIL nop_flag_cleared_by_flush: data=%h daddr=%h required 99999999aaaaaaaa/00000808",
                     bus.data, bus.data_addr);
        end
        step();
        n_checks++;
        if (bus.ifu_req_addr !== 32'h0000_0810) begin
            n_fail++; $display("FAIL flush_hold_next: addr=%h required 00000810", bus.ifu_req_addr);
        end
    endtask

    task automatic test_reset_mid();
        bus.ifu_req_ack = 1'b1;
        step();
        bus.ifu_req_ack = 1'b0;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.ifu_req, bus.ifu_req_addr, bus.data_vld, bus.data, bus.data_addr} !== 130'd0) begin
            n_fail++;
            $display("FAIL reset_async: req=%0b addr=%h vld=%0b data=%h daddr=%h required all zero",
                     bus.ifu_req, bus.ifu_req_addr, bus.data_vld, bus.data, bus.data_addr);
        end
`ifdef C7BIFU_FCU_PERF_EN
        n_checks++;
        if (fcu_beat_cnt !== 32'd0 || fcu_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: beat=%0d stall=%0d required 0/0", fcu_beat_cnt, fcu_stall_cnt);
        end
`endif
        step();
        resetn = 1'b1;
        step();
        n_checks++;
        if (bus.ifu_req !== 1'b1 || bus.ifu_req_addr !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL reset_restart: req=%0b addr=%h required 1/1c000000", bus.ifu_req, bus.ifu_req_addr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_hold_stall();
        test_flush_wait();
        test_flush_rvld();
        test_wrap();
        test_flush_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c7bifu_fcu.md
C7BIFU_FCU -- requirements
Module: c7bifu_fcu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h1c000000, meaning the first fetch address after reset.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  redirect strobe; single cycle; priority over every other event.
REQ-005 flush_pc  input  32  redirect target; bits [1:0] SHALL be ignored.
REQ-006 ifu_req  output  1  memory read request, held until acknowledged.
REQ-007 ifu_req_addr  output  32  request address, always 8-byte aligned.
REQ-008 ifu_req_ack  input  1  memory accepts request when ifu_req && ifu_req_ack.
REQ-009 mem_rvld  input  1  64-bit read response valid, one cycle per accepted request, in order.
REQ-010 mem_rdata  input  64  response data; [31:0] holds the lower address.
REQ-011 data_addr  output  32  aligned address of the delivered beat; the downstream queue places data[63:32] at data_addr+4.
REQ-012 data  output  64  delivered beat.
REQ-013 data_vld  output  1  beat valid; transfer occurs when data_vld && !iq_full.
REQ-014 iq_full  input  1  downstream instruction queue cannot accept a beat.

Function
REQ-015 The block SHALL keep at most one memory request outstanding.
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP.
REQ-017 IDLE -> REQ unconditionally after one cycle.
REQ-018 REQ: ifu_req=1, ifu_req_addr={fetch_pc[31:3],3'b0}; on ack -> WAIT.
REQ-019 WAIT: on mem_rvld, load data/data_addr registers -> HOLD; data_vld=1 from the next cycle.
REQ-020 HOLD: data, data_addr and data_vld SHALL stay stable while iq_full=1; on transfer, fetch_pc <= aligned fetch_pc + 8 (mod 2^32) -> REQ with data_vld=0 the next cycle.
REQ-021 DROP: an in-flight response SHALL be discarded; on mem_rvld -> REQ.
REQ-022 On flush: fetch_pc <= {flush_pc[31:2],2'b00}; data_vld <= 0 next cycle.
REQ-023 flush in IDLE, REQ without ack, or HOLD -> REQ.
REQ-024 flush in REQ with same-cycle ack, or in WAIT without mem_rvld -> DROP.
REQ-025 flush in WAIT with same-cycle mem_rvld -> REQ; the response is not loaded.
REQ-026 flush in DROP -> DROP with updated fetch_pc; same-cycle mem_rvld -> REQ.
REQ-027 When a redirect target has bit 2 set, the next delivered beat SHALL have data[31:0] replaced with NOP_INST (32'h03400000); this flag SHALL clear on that beat's transfer or on a later flush with flush_pc[2]=0.
REQ-028 mem_rvld in IDLE, REQ or HOLD SHALL be ignored.
REQ-029 Minimum spacing between transfers SHALL be 3 cycles (REQ, WAIT, HOLD).

Reset
REQ-030 Reset SHALL set the state to IDLE and fetch_pc to RESET_PC.
REQ-031 Reset SHALL set ifu_req=0, ifu_req_addr=0, data_vld=0, data=0, data_addr=0 and clear the NOP flag.
REQ-032 Reset asserted mid-request SHALL abandon the request; no response is expected afterwards.

Configuration
REQ-033 With C7BIFU_FCU_PERF_EN defined, the block SHALL have outputs fcu_beat_cnt[31:0] (+1 per transfer) and fcu_stall_cnt[31:0] (+1 per HOLD cycle with iq_full=1).
REQ-034 Both counters SHALL wrap, be cleared only by reset, and be unaffected by flush.
REQ-035 Without C7BIFU_FCU_PERF_EN, these ports and counters SHALL be absent and the remaining behaviour identical.

Structure
REQ-036 Package c7bifu_pkg SHALL hold the FSM state typedef, NOP_INST and FETCH_BYTES=8.
REQ-037 Sub-module c7bifu_fcu_perf SHALL implement the counters and be instantiated only under C7BIFU_FCU_PERF_EN.

Verification
REQ-038 Reset release, ack at once, rvld with 64'h11111111_22222222 -> req addr 1c000000; beat data_addr=1c000000; next req addr 1c000008.
REQ-039 iq_full=1 for 5 cycles in HOLD -> data/data_addr stable, data_vld=1 throughout; fcu_stall_cnt=5 with macro.
REQ-040 flush_pc=32'h1c000104 during WAIT, rvld 2 cycles later -> response discarded; req addr 1c000100; delivered data[31:0]=03400000.
REQ-041 flush in the same cycle as mem_rvld in WAIT -> no beat delivered; next req uses the flush target.
REQ-042 fetch_pc=32'hFFFFFFF8 beat transferred -> next req addr 32'h00000000.
REQ-043 resetn low during WAIT -> all outputs reach reset values immediately; after release, state is IDLE then REQ at RESET_PC.
